// File: rtl/mix_columns_pipe_if.sv
// Handshake bundle for the MixColumns engine: one input block channel and one result channel.
// The slave modport is the engine's view; the master modport is the producer/consumer side.
interface mix_columns_pipe_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         in_bypass;
    logic         in_inv;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;

    modport master (
        output in_valid, in_data, in_bypass, in_inv, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, in_bypass, in_inv, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/mix_columns_pipe.sv
// AES MixColumns engine processing COLS_PER_CYCLE columns per cycle with a bypass path.
// Defining MIX_COLUMNS_INV_EN adds InvMixColumns, selected per block by in_inv.
module mix_columns_pipe #(
    parameter int COLS_PER_CYCLE = 1
) (
    input logic               clk,
    input logic               rst_n,
    mix_columns_pipe_if.slave bus
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t       state_reg;
    logic [127:0] data_reg;
    logic [127:0] result_reg;
    logic [127:0] result_next;
    logic [2:0]   col_reg;
    logic         bypass_reg;
    logic         inv_reg;
    logic         valid_reg;
    logic         accept;
    logic         last_group;

    logic [1:0]  sel     [COLS_PER_CYCLE];
    logic [31:0] col_in  [COLS_PER_CYCLE];
    logic [31:0] col_out [COLS_PER_CYCLE];

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] fwd_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = c;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

`ifdef MIX_COLUMNS_INV_EN
    // Multiply by 9/B/D/E built from the x2, x4, x8 doubling chain.
    function automatic logic [7:0] gm(input logic [7:0] a, input logic [3:0] k);
        logic [7:0] x2, x4, x8;
        x2 = xtime(a);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return (k[3] ? x8 : 8'h00) ^ (k[2] ? x4 : 8'h00) ^
               (k[1] ? x2 : 8'h00) ^ (k[0] ? a : 8'h00);
    endfunction

    function automatic logic [31:0] inv_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = c;
        return {gm(a0, 4'he) ^ gm(a1, 4'hb) ^ gm(a2, 4'hd) ^ gm(a3, 4'h9),
                gm(a0, 4'h9) ^ gm(a1, 4'he) ^ gm(a2, 4'hb) ^ gm(a3, 4'hd),
                gm(a0, 4'hd) ^ gm(a1, 4'h9) ^ gm(a2, 4'he) ^ gm(a3, 4'hb),
                gm(a0, 4'hb) ^ gm(a1, 4'hd) ^ gm(a2, 4'h9) ^ gm(a3, 4'he)};
    endfunction
`endif

    for (genvar gi = 0; gi < COLS_PER_CYCLE; gi++) begin : g_col
        assign sel[gi]    = col_reg[1:0] + 2'(gi);
        assign col_in[gi] = data_reg[{2'd3 - sel[gi], 5'd0} +: 32];
`ifdef MIX_COLUMNS_INV_EN
        assign col_out[gi] = inv_reg ? inv_col(col_in[gi]) : fwd_col(col_in[gi]);
`else
        assign col_out[gi] = fwd_col(col_in[gi]);
`endif
    end

`ifdef MIX_COLUMNS_INV_EN
    wire unused_flags = &{1'b0, bypass_reg};
`else
    wire unused_flags = &{1'b0, bypass_reg, inv_reg};
`endif

    always_comb begin
        result_next = result_reg;
        for (int i = 0; i < COLS_PER_CYCLE; i++) begin
            result_next[{2'd3 - sel[i], 5'd0} +: 32] = col_out[i];
        end
    end

    assign last_group   = (col_reg == 3'(4 - COLS_PER_CYCLE));
    assign bus.in_ready = (state_reg == IDLE) || ((state_reg == DONE) && bus.out_ready);
    assign accept       = bus.in_valid && bus.in_ready;
    assign bus.out_valid = valid_reg;
    assign bus.out_data  = result_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            data_reg   <= '0;
            result_reg <= '0;
            col_reg    <= '0;
            bypass_reg <= 1'b0;
            inv_reg    <= 1'b0;
            valid_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    // In DONE, accept implies out_ready, so retiring and loading share this edge.
                    if (accept) begin
                        data_reg   <= bus.in_data;
                        bypass_reg <= bus.in_bypass;
                        inv_reg    <= bus.in_inv;
                        col_reg    <= '0;
                        if (bus.in_bypass) begin
                            result_reg <= bus.in_data;
                            valid_reg  <= 1'b1;
                            state_reg  <= DONE;
                        end else begin
                            valid_reg  <= 1'b0;
                            state_reg  <= BUSY;
                        end
                    end else if ((state_reg == DONE) && bus.out_ready) begin
                        valid_reg <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                BUSY: begin
                    result_reg <= result_next;
                    col_reg    <= col_reg + 3'(COLS_PER_CYCLE);
                    if (last_group) begin
                        valid_reg <= 1'b1;
                        state_reg <= DONE;
                    end
                end
                default: begin
                    valid_reg <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mix_columns_pipe.sv
// Scoreboard bench driving three engine instances (1, 2 and 4 columns per cycle) with
// spec vectors, random blocks, back-pressure, back-to-back transfer and mid-block reset.
module tb_mix_columns_pipe;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic         in_valid  [3];
    logic         in_bypass [3];
    logic         in_inv    [3];
    logic         out_ready [3];
    logic [127:0] in_data   [3];
    logic         in_ready  [3];
    logic         out_valid [3];
    logic [127:0] out_data  [3];

    logic [127:0] exp_q [3][$];
    int errors = 0;
    int checks = 0;

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        mix_columns_pipe_if bus ();
        assign bus.in_valid  = in_valid[gi];
        assign bus.in_bypass = in_bypass[gi];
        assign bus.in_inv    = in_inv[gi];
        assign bus.in_data   = in_data[gi];
        assign bus.out_ready = out_ready[gi];
        assign in_ready[gi]  = bus.in_ready;
        assign out_valid[gi] = bus.out_valid;
        assign out_data[gi]  = bus.out_data;
        mix_columns_pipe #(.COLS_PER_CYCLE(1 << gi)) dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus)
        );
    end

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [127:0] model(input logic [127:0] blk, input logic inv);
        logic [7:0] coef [4];
        logic [7:0] a [4];
        logic [7:0] b;
        logic [127:0] r = '0;
        if (inv) coef = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        else     coef = '{8'h02, 8'h03, 8'h01, 8'h01};
        for (int c = 0; c < 4; c++) begin
            for (int j = 0; j < 4; j++) a[j] = blk[127 - 32*c - 8*j -: 8];
            for (int rr = 0; rr < 4; rr++) begin
                b = 8'h00;
                for (int j = 0; j < 4; j++) b ^= gmul(coef[(j - rr) & 3], a[j]);
                r[127 - 32*c - 8*rr -: 8] = b;
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] expect_for(input logic [127:0] blk, input logic inv);
`ifdef MIX_COLUMNS_INV_EN
        return model(blk, inv);
`else
        return model(blk, 1'b0);
`endif
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Caller is at a negedge; returns #1 after the accept edge.
    task automatic send(input int k, input logic [127:0] d, input logic byp, input logic inv,
                        input logic [127:0] e, input logic push);
        int n = 0;
        in_valid[k]  = 1'b1;
        in_data[k]   = d;
        in_bypass[k] = byp;
        in_inv[k]    = inv;
        if (push) exp_q[k].push_back(e);
        while (!in_ready[k] && n < 16) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("accept_ready[%0d]", k), 128'(in_ready[k]), 128'(1));
        @(posedge clk);
        #1;
        in_valid[k]  = 1'b0;
        in_data[k]   = {$urandom, $urandom, $urandom, $urandom};
        in_bypass[k] = 1'($urandom);
        in_inv[k]    = 1'($urandom);
    endtask

    // Counts negedges after the accept edge until out_valid, then checks latency and data.
    task automatic wait_out(input int k, input int exp_lat, output logic [127:0] got_exp);
        int lat = 0;
        got_exp = '0;
        @(negedge clk);
        while (!out_valid[k] && lat < 16) begin
            @(negedge clk);
            lat++;
        end
        check($sformatf("latency[%0d]", k), 128'(lat), 128'(exp_lat));
        if (exp_q[k].size() == 0) begin
            check($sformatf("queue_nonempty[%0d]", k), 128'(0), 128'(1));
        end else begin
            got_exp = exp_q[k].pop_front();
            check($sformatf("out_data[%0d]", k), out_data[k], got_exp);
        end
        check($sformatf("ready_low_in_done[%0d]", k), 128'(in_ready[k]), 128'(0));
    endtask

    task automatic retire(input int k);
        out_ready[k] = 1'b1;
        @(posedge clk);
        #1;
        out_ready[k] = 1'b0;
        @(negedge clk);
        check($sformatf("idle_valid[%0d]", k), 128'(out_valid[k]), 128'(0));
        check($sformatf("idle_ready[%0d]", k), 128'(in_ready[k]), 128'(1));
    endtask

    task automatic xact(input int k, input logic [127:0] d, input logic byp, input logic inv,
                        input logic [127:0] e);
        logic [127:0] dummy;
        send(k, d, byp, inv, e, 1'b1);
        wait_out(k, byp ? 0 : (4 >> k), dummy);
        retire(k);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    localparam logic [127:0] VEC_IN  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    localparam logic [127:0] VEC_FWD = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    localparam logic [127:0] VEC_BYP = 128'hd4d4d4d5_2d26314c_00000000_ffffffff;

    initial begin
        logic [127:0] blk, exp_a, exp_b, got;
        logic inv_bit;
        int seen;
        for (int k = 0; k < 3; k++) begin
            in_valid[k] = 1'b0; in_bypass[k] = 1'b0; in_inv[k] = 1'b0;
            in_data[k] = '0; out_ready[k] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("rst_valid[%0d]", k), 128'(out_valid[k]), 128'(0));
            check($sformatf("rst_ready[%0d]", k), 128'(in_ready[k]), 128'(1));
            check($sformatf("rst_data[%0d]", k), out_data[k], 128'(0));
        end
        rst_n = 1'b1;

        // Spec forward vector; first block accepted on the first edge after release.
        for (int k = 0; k < 3; k++) xact(k, VEC_IN, 1'b0, 1'b0, VEC_FWD);
        // Bypass with either in_inv value.
        for (int k = 0; k < 3; k++) xact(k, VEC_BYP, 1'b1, 1'(k & 1), VEC_BYP);
        // Inverse request: inverse result when enabled, forward result otherwise.
        for (int k = 0; k < 3; k++) begin
`ifdef MIX_COLUMNS_INV_EN
            xact(k, VEC_FWD, 1'b0, 1'b1, VEC_IN);
`else
            xact(k, VEC_FWD, 1'b0, 1'b1, model(VEC_FWD, 1'b0));
`endif
        end
        // Random blocks through the reference model.
        for (int k = 0; k < 3; k++) begin
            for (int t = 0; t < 3; t++) begin
                blk = {$urandom, $urandom, $urandom, $urandom};
                inv_bit = 1'($urandom);
                xact(k, blk, 1'b0, inv_bit, expect_for(blk, inv_bit));
            end
        end

        // Back-pressure then retire-and-accept on the same edge (2 columns per cycle).
        blk = {$urandom, $urandom, $urandom, $urandom};
        exp_a = model(blk, 1'b0);
        send(1, blk, 1'b0, 1'b0, exp_a, 1'b1);
        wait_out(1, 2, got);
        blk = {$urandom, $urandom, $urandom, $urandom};
        exp_b = model(blk, 1'b0);
        in_valid[1] = 1'b1; in_data[1] = blk; in_bypass[1] = 1'b0; in_inv[1] = 1'b0;
        exp_q[1].push_back(exp_b);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check($sformatf("hold_valid[%0d]", c), 128'(out_valid[1]), 128'(1));
            check($sformatf("hold_data[%0d]", c), out_data[1], exp_a);
            check($sformatf("hold_ready[%0d]", c), 128'(in_ready[1]), 128'(0));
        end
        out_ready[1] = 1'b1;
        #1;
        check("b2b_ready", 128'(in_ready[1]), 128'(1));
        @(posedge clk);
        #1;
        out_ready[1] = 1'b0;
        in_valid[1] = 1'b0;
        wait_out(1, 2, got);
        retire(1);

        // Reset while busy discards the block.
        send(0, VEC_IN, 1'b0, 1'b0, '0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_valid", 128'(out_valid[0]), 128'(0));
        check("midrst_data", out_data[0], 128'(0));
        check("midrst_ready", 128'(in_ready[0]), 128'(1));
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (out_valid[0]) seen++;
        end
        check("postrst_no_valid", 128'(seen), 128'(0));
        xact(0, VEC_IN, 1'b0, 1'b0, VEC_FWD);

        for (int k = 0; k < 3; k++)
            check($sformatf("queue_empty[%0d]", k), 128'(exp_q[k].size()), 128'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mix_columns_pipe.md
MIX_COLUMNS_PIPE -- requirements
Module: mix_columns_pipe

Interface
REQ-001 Parameter COLS_PER_CYCLE, default 1, number of 32-bit columns transformed per BUSY cycle; legal values 1, 2, 4.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  input block present.
REQ-005 in_ready  output  1  block accepted when in_valid and in_ready are both 1 at a clk edge.
REQ-006 in_data  input  128  AES state; column c at bits [127-32c -: 32]; row 0 in the MSB byte of each column.
REQ-007 in_bypass  input  1  sampled with in_data; 1 passes the block through unchanged (first/final round).
REQ-008 in_inv  input  1  sampled with in_data; 1 selects InvMixColumns (see REQ-025).
REQ-009 out_valid  output  1  out_data holds a completed block.
REQ-010 out_ready  input  1  consumer accepts when out_valid and out_ready are both 1.
REQ-011 out_data  output  128  result, same byte layout as in_data.

Function
REQ-012 FSM states: IDLE, BUSY, DONE.
REQ-013 in_ready = (state==IDLE) or (state==DONE and out_ready); no other path.
REQ-014 On accept: capture in_data, in_bypass and in_inv into internal registers; clear column counter to 0.
REQ-015 Accept with in_bypass=1: out_data <= in_data, next state DONE (1-cycle latency).
REQ-016 Accept with in_bypass=0: next state BUSY.
REQ-017 BUSY: each cycle transform columns counter..counter+COLS_PER_CYCLE-1 into the result register; counter += COLS_PER_CYCLE.
REQ-018 Last column group written: next state DONE; latency accept-edge to out_valid = 4/COLS_PER_CYCLE cycles.
REQ-019 Forward transform per column (a0..a3 -> b0..b3), GF(2^8) with xtime reduction polynomial 0x11B: b0=2a0^3a1^a2^a3, b1=a0^2a1^3a2^a3, b2=a0^a1^2a2^3a3, b3=3a0^a1^a2^2a3.
REQ-020 out_valid = 1 exactly in DONE; out_data stable from DONE entry until handshake.
REQ-021 DONE with out_ready=1 and in_valid=0: next state IDLE.
REQ-022 DONE with out_ready=1 and in_valid=1: output retired and new block accepted on the same edge (back-to-back, no IDLE bubble).
REQ-023 DONE with out_ready=0: hold state, out_data and internal registers; in_valid ignored.
REQ-024 in_data, in_bypass, in_inv are don't-care in BUSY; no change to the captured block.

Configuration
REQ-025 Macro MIX_COLUMNS_INV_EN defined: in_inv=1 applies InvMixColumns b0=Ea0^Ba1^Da2^9a3, b1=9a0^Ea1^Ba2^Da3, b2=Da0^9a1^Ea2^Ba3, b3=Ba0^Da1^9a2^Ea3, same latency as forward.
REQ-026 Macro undefined: in_inv ignored, forward transform only, no inverse logic synthesised.

Reset
REQ-027 rst_n=0 forces immediately: state IDLE, out_valid=0, in_ready=1, out_data=128'h0, counter=0, captured flags=0.
REQ-028 Reset mid-BUSY or mid-DONE discards the block; no out_valid after release until a new accept.
REQ-029 First accept possible on the first rising edge with rst_n=1.

Verification
REQ-030 COLS_PER_CYCLE=1, column 0 = db135345, forward -> column 0 = 8e4da1bc; out_valid 4 cycles after accept.
REQ-031 COLS_PER_CYCLE=4, in_data = db135345_f20a225c_01010101_c6c6c6c6 -> 8e4da1bc_9fdc589d_01010101_c6c6c6c6, out_valid 1 cycle after accept.
REQ-032 in_bypass=1, in_data = d4d4d4d5_2d26314c_00000000_ffffffff -> identical out_data 1 cycle later, any in_inv.
REQ-033 MIX_COLUMNS_INV_EN defined, in_inv=1, 8e4da1bc_9fdc589d_01010101_c6c6c6c6 -> db135345_f20a225c_01010101_c6c6c6c6; undefined: same stimulus yields forward result.
REQ-034 COLS_PER_CYCLE=2: hold out_ready=0 for 5 cycles in DONE -> out_data stable, in_ready=0; then out_ready=1 with in_valid=1 -> retire and accept on the same edge, next out_valid 2 cycles later.
REQ-035 Assert rst_n=0 during BUSY -> out_valid=0 and out_data=0 immediately; after release, no out_valid without a new accept.
